// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
//   - 4-bit opcode constants and the legality check used by the controller.
//   - Controller state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_PASS_A = 4'b0000;
  localparam logic [OP_W-1:0] OP_PASS_B = 4'b0001;
  localparam logic [OP_W-1:0] OP_NOT    = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND    = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR     = 4'b0100;
  localparam logic [OP_W-1:0] OP_ZERO   = 4'b0101;
  localparam logic [OP_W-1:0] OP_ADD    = 4'b1000;
  localparam logic [OP_W-1:0] OP_DEC    = 4'b1001;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b1010;
  localparam logic [OP_W-1:0] OP_INC    = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_PASS_A, OP_PASS_B, OP_NOT, OP_AND, OP_OR,
      OP_ZERO, OP_ADD, OP_DEC, OP_SUB, OP_INC: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command / result handshake bundle for alu_seq_ctrl.
//   cmd_*: requester -> controller (valid/ready), op, operand, repeat count.
//   res_*: controller -> consumer (valid/ready), data, zero and error flags.
//   slave modport: controller side.  master modport: requester/consumer side.
interface alu_seq_ctrl_if #(
  parameter int unsigned N = 8,
  parameter int unsigned C = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_operand;
  logic [C-1:0] cmd_count;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_zero;
  logic         res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, cmd_count, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_operand, cmd_count, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_err
  );
endinterface

// File: rtl/alu.sv
// Combinational N-bit ALU.
//   a, b : operands; op : 4-bit opcode; y : result (wraps modulo 2^N).
//   Illegal opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    y
);

  always_comb begin
    y = '0;
    case (op)
      OP_PASS_A: y = a;
      OP_PASS_B: y = b;
      OP_NOT:    y = ~a;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_ZERO:   y = '0;
      OP_ADD:    y = a + b;
      OP_DEC:    y = a - N'(1);
      OP_SUB:    y = a - b;
      OP_INC:    y = a + N'(1);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around the shared ALU.
//   clk, rst_n : clock, async active-low reset.
//   bus        : alu_seq_ctrl_if.slave -- command in, result out.
// Each accepted command applies its op to the persistent accumulator and the
// command operand count+1 times, then presents the accumulator until taken.
// Illegal opcodes skip RUN and report res_err with the accumulator untouched.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned C = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [C-1:0]      cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [N-1:0]      operand_q, operand_d;
  logic              err_q, err_d;
  logic [N-1:0]      alu_y;

  alu #(.N(N)) u_alu (
    .a  (acc_q),
    .b  (operand_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    operand_d = operand_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          operand_d = bus.cmd_operand;
          if (is_legal_op(bus.cmd_op)) begin
            cnt_d   = bus.cmd_count;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        acc_d = alu_y;
        // Final iteration leaves RUN on the same edge that commits it.
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - C'(1);
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = acc_q;
  assign bus.res_zero  = (acc_q == '0);
  assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.N(8), .C(4)) bus ();

  alu_seq_ctrl #(.N(8), .C(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] operand, input logic [3:0] count);
    @(negedge clk);
    check("cmd_ready_before_issue", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = operand;
    bus.cmd_count   = count;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
  endtask

  // Wait (bounded) for res_valid, then check latency and result fields.
  task automatic wait_res(input string tag, input int exp_lat, input logic [7:0] exp_data, input logic exp_err);
    int lat;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, {24'd0, bus.res_data}, {24'd0, exp_data});
    check({tag, "_zero"}, {31'd0, bus.res_zero}, {31'd0, (exp_data == 8'h00)});
    check({tag, "_err"}, {31'd0, bus.res_err}, {31'd0, exp_err});
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_after_release_valid", {31'd0, bus.res_valid}, 32'd0);
    check("idle_after_release_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_operand = 8'h00;
    bus.cmd_count   = 4'h0;
    bus.res_ready   = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data",  {24'd0, bus.res_data}, 32'd0);
    check("rst_res_zero",  {31'd0, bus.res_zero}, 32'd1);
    check("rst_res_err",   {31'd0, bus.res_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load, repeated add, repeated decrement
    issue(4'b0001, 8'h05, 4'h0);  wait_res("load05", 1, 8'h05, 1'b0);  release_res();
    issue(4'b1000, 8'h03, 4'h4);  wait_res("add3x5", 5, 8'h14, 1'b0);  release_res();
    issue(4'b1001, 8'h00, 4'hF);  wait_res("dec16", 16, 8'h04, 1'b0);  release_res();

    // Wrap-around
    issue(4'b0001, 8'hFE, 4'h0);  wait_res("loadFE", 1, 8'hFE, 1'b0);  release_res();
    issue(4'b1011, 8'h00, 4'h2);  wait_res("inc3_wrap", 3, 8'h01, 1'b0); release_res();
    issue(4'b0001, 8'h01, 4'h0);  wait_res("load01", 1, 8'h01, 1'b0);  release_res();
    issue(4'b1010, 8'h02, 4'h0);  wait_res("sub_wrap", 1, 8'hFF, 1'b0); release_res();

    // Logic ops
    issue(4'b0001, 8'h3C, 4'h0);  wait_res("load3C", 1, 8'h3C, 1'b0);  release_res();
    issue(4'b0011, 8'h0F, 4'h0);  wait_res("and0F", 1, 8'h0C, 1'b0);   release_res();
    issue(4'b0100, 8'hA0, 4'h0);  wait_res("orA0", 1, 8'hAC, 1'b0);    release_res();
    issue(4'b0010, 8'h00, 4'h0);  wait_res("not", 1, 8'h53, 1'b0);     release_res();
    issue(4'b0000, 8'hFF, 4'h3);  wait_res("pass_a", 4, 8'h53, 1'b0);  release_res();
    issue(4'b0101, 8'h77, 4'h0);  wait_res("zero", 1, 8'h00, 1'b0);    release_res();

    // Illegal opcode: straight to DONE, acc untouched
    issue(4'b0001, 8'h2A, 4'h0);  wait_res("load2A", 1, 8'h2A, 1'b0);  release_res();
    issue(4'b1100, 8'h11, 4'h5);  wait_res("illegal", 0, 8'h2A, 1'b1); release_res();
    issue(4'b0000, 8'h00, 4'h0);  wait_res("after_illegal", 1, 8'h2A, 1'b0); release_res();

    // Back-pressure with a pending command
    issue(4'b0001, 8'h10, 4'h0);  wait_res("load10", 1, 8'h10, 1'b0);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = 4'b1011;
    bus.cmd_operand = 8'h00;
    bus.cmd_count   = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("bp_res_data",  {24'd0, bus.res_data}, 32'h10);
      check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    check("bp_accepted", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b0;
    wait_res("bp_inc_once", 1, 8'h11, 1'b0);
    release_res();

    // Reset mid-RUN
    issue(4'b1000, 8'h01, 4'hF);
    repeat (3) @(negedge clk);
    check("midrun_valid", {31'd0, bus.res_valid}, 32'd0);
    check("midrun_data",  {24'd0, bus.res_data}, 32'h14);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("mrst_res_data",  {24'd0, bus.res_data}, 32'd0);
    check("mrst_res_zero",  {31'd0, bus.res_zero}, 32'd1);
    check("mrst_res_err",   {31'd0, bus.res_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'b1000, 8'h07, 4'h0);  wait_res("post_rst_add", 1, 8'h07, 1'b0); release_res();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
